// File: rtl/atm_session_driver.sv
// atm_session_driver
//   Initiator-side sequencer for the ATM controller. It takes customer requests
//   (PIN, operation, amount) over a valid/ready interface, walks the ATM
//   through a card session (insert, language, PIN, operation, continue/eject)
//   and returns one status response per accepted request.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_*               request channel (valid/ready, pin, opcode, amount,
//                       language, last = eject after this operation)
//   rsp_valid/status    one-cycle response pulse; status holds until next one
//   cardIn .. ejectCard drive signals toward the ATM
//   correctPassword ..  status flags from the ATM, sampled synchronously
//   ATM_Usage_Finished
module atm_session_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int AMOUNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_pin,
  input  logic [1:0]          req_opcode,
  input  logic [AMOUNT_W-1:0] req_amount,
  input  logic                req_language,
  input  logic                req_last,
  output logic                rsp_valid,
  output logic [1:0]          rsp_status,
  output logic                cardIn,
  output logic                Language,
  output logic [3:0]          password,
  output logic [1:0]          opCode,
  output logic [AMOUNT_W-1:0] inputAmount,
  output logic                moneyDeposited,
  output logic                Another_Operation,
  output logic                ejectCard,
  input  logic                correctPassword,
  input  logic                Balance_Shown,
  input  logic                Deposited_Successfully,
  input  logic                Withdrawed_Successfully,
  input  logic                ATM_Usage_Finished
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, INSERT, LANG, PIN, WAIT_PIN, OP, WAIT_DONE, EJECT, WAIT_FIN, RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK, ST_BAD_PIN, ST_TIMEOUT, ST_SESSION_END
  } status_t;

  state_t                state, state_n;
  status_t               status_q, status_n;
  logic [TW-1:0]         timer;
  logic                  session_open;
  logic [3:0]            pin_q;
  logic [1:0]            op_q;
  logic [AMOUNT_W-1:0]   amt_q;
  logic                  lang_q;
  logic                  last_q;

  logic                  timed_out;
  logic                  in_wait;
  logic                  done_match;
  logic [1:0]            cur_op;
  logic [AMOUNT_W-1:0]   cur_amt;

  assign req_ready = (state == IDLE);

  // A chained request goes IDLE -> OP on the same edge it is latched, so the
  // OP drive values must come straight from the request bus in that case.
  assign cur_op  = (state == IDLE) ? req_opcode : op_q;
  assign cur_amt = (state == IDLE) ? req_amount : amt_q;

  always_comb begin
    state_n    = state;
    status_n   = status_q;
    timed_out  = (timer == TW'(TIMEOUT_CYCLES));
    in_wait    = (state == WAIT_PIN) || (state == WAIT_DONE) || (state == WAIT_FIN);
    done_match = 1'b0;
    case (op_q)
      2'b01:   done_match = Balance_Shown;
      2'b10:   done_match = Deposited_Successfully;
      2'b11:   done_match = Withdrawed_Successfully;
      default: done_match = 1'b0;
    endcase

    case (state)
      IDLE: begin
        if (req_valid) begin
          status_n = ST_OK;
          if (req_opcode == 2'b00) begin
            if (session_open) begin
              state_n = EJECT;
            end else begin
              state_n  = RESP;
              status_n = ST_SESSION_END;
            end
          end else if (session_open) begin
            state_n = OP;
          end else begin
            state_n = INSERT;
          end
        end
      end
      INSERT: state_n = LANG;
      LANG:   state_n = PIN;
      PIN:    state_n = WAIT_PIN;
      WAIT_PIN: begin
        if (correctPassword) begin
          state_n = OP;
        end else if (timed_out) begin
          state_n  = EJECT;
          status_n = ST_BAD_PIN;
        end
      end
      OP: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (done_match) begin
          status_n = ST_OK;
          state_n  = last_q ? EJECT : RESP;
        end else if (timed_out) begin
          state_n  = EJECT;
          status_n = ST_TIMEOUT;
        end
      end
      EJECT: state_n = WAIT_FIN;
      WAIT_FIN: begin
        if (ATM_Usage_Finished) begin
          state_n = RESP;
        end else if (timed_out) begin
          state_n = RESP;
          if (status_q == ST_OK) status_n = ST_TIMEOUT;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ATM-side outputs are registered and loaded from state_n so that each one
  // is valid during the cycle of the state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      status_q          <= ST_OK;
      timer             <= '0;
      session_open      <= 1'b0;
      pin_q             <= '0;
      op_q              <= '0;
      amt_q             <= '0;
      lang_q            <= 1'b0;
      last_q            <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_status        <= '0;
      cardIn            <= 1'b0;
      Language          <= 1'b0;
      password          <= '0;
      opCode            <= '0;
      inputAmount       <= '0;
      moneyDeposited    <= 1'b0;
      Another_Operation <= 1'b0;
      ejectCard         <= 1'b0;
    end else begin
      state    <= state_n;
      status_q <= status_n;

      if (state_n != state || !in_wait) timer <= '0;
      else                              timer <= timer + TW'(1);

      if (state == IDLE && req_valid) begin
        pin_q  <= req_pin;
        op_q   <= req_opcode;
        amt_q  <= req_amount;
        lang_q <= req_language;
        last_q <= req_last;
      end

      if (state == WAIT_PIN && correctPassword) session_open <= 1'b1;
      else if (state_n == EJECT)                 session_open <= 1'b0;

      if (state_n == INSERT)     cardIn <= 1'b1;
      else if (state_n == EJECT) cardIn <= 1'b0;

      if (state_n == LANG) Language <= lang_q;
      if (state_n == PIN)  password <= pin_q;
      if (state_n == OP) begin
        opCode      <= cur_op;
        inputAmount <= cur_amt;
      end

      if (state == WAIT_FIN && state_n == RESP) begin
        Language    <= 1'b0;
        password    <= '0;
        opCode      <= '0;
        inputAmount <= '0;
      end

      moneyDeposited    <= (state_n == OP) && (cur_op == 2'b10);
      ejectCard         <= (state_n == EJECT);
      Another_Operation <= (state == WAIT_DONE) && (state_n == RESP);
      rsp_valid         <= (state_n == RESP);
      if (state_n == RESP) rsp_status <= status_n;
    end
  end

endmodule
